// File: rtl/hv_cmd_pkg.sv
// Shared definitions for the hypervisor command path: status codes, opcodes,
// CDB field offsets and the fetch FSM encoding.
package hv_cmd_pkg;

  localparam int unsigned CDB_W          = 256;
  localparam int unsigned CDB_OP_LSB     = 0;
  localparam int unsigned CDB_TAG_LSB    = 8;
  localparam int unsigned CDB_QIDX_LSB   = 16;
  localparam int unsigned CDB_STATUS_LSB = 24;
  localparam int unsigned CDB_TBM_LSB    = 160;

  typedef enum logic [7:0] {
    CS_NONE        = 8'd0,
    CS_CKS_ERROR   = 8'd1,
    CS_FETCHED     = 8'd2,
    CS_QUEUED      = 8'd3,
    CS_H2M         = 8'd4,
    CS_Q2S         = 8'd5,
    CS_S2Q         = 8'd6,
    CS_M2H         = 8'd7,
    CS_COMPLETE    = 8'd8,
    CS_ABORTED     = 8'd9,
    CS_TIMEOUT     = 8'd10,
    CS_NO_RESOURCE = 8'd11,
    CS_INVALID     = 8'd12
  } cmd_status_e;

  typedef enum logic [7:0] {
    OP_WRITE = 8'h01,
    OP_READ  = 8'h02
  } cmd_opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAP,
    ST_DECODE,
    ST_ALLOC,
    ST_UPDATE,
    ST_ISSUE
  } fetch_state_e;

  function automatic logic op_supported(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/hv_tbm_alloc.sv
// TBM slot bitmap with a lowest-index-first priority encoder.
// A free and a grant of the same slot in one cycle leave the slot busy.
module hv_tbm_alloc
  import hv_cmd_pkg::*;
#(
  parameter int unsigned SLOTS  = 16,
  parameter int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [SLOT_W-1:0] alloc_slot,
  input  logic              free_ie,
  input  logic [3:0]        free_slot,
  output logic              all_busy
);

  logic [SLOTS-1:0] busy_q;
  logic [SLOTS-1:0] busy_d;

  assign all_busy  = &busy_q;
  assign alloc_gnt = alloc_req & ~all_busy;

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    alloc_slot = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_slot = SLOT_W'(i);
    end
  end

  for (genvar gi = 0; gi < int'(SLOTS); gi++) begin : g_slot
    logic free_hit;
    logic gnt_hit;
    assign free_hit   = free_ie && (int'(free_slot) == gi);
    assign gnt_hit    = alloc_gnt && (int'(alloc_slot) == gi);
    assign busy_d[gi] = (busy_q[gi] & ~free_hit) | gnt_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/hv_cmd_fetch.sv
// Command fetch: pulls a CDB from the command queue in beats, validates it,
// binds a TBM slot, writes status/address back and hands the CDB to the engine.
module hv_cmd_fetch
  import hv_cmd_pkg::*;
#(
  parameter int unsigned CMD_IO_WIDTH   = 64,
  parameter int unsigned TBM_SLOTS      = 16,
  parameter logic [31:0] TBM_BASE       = 32'h0000_0000,
  parameter int unsigned TBM_SLOT_BYTES = 4096,
  parameter int unsigned BEAT_TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cq_cout_ready,
  output logic                    cmd_request,
  input  logic                    cmd_oe,
  input  logic [CMD_IO_WIDTH-1:0] cmd_out,
  output logic [7:0]              op_index,
  output logic [7:0]              cmd_op_status,
  output logic                    tbm_ie,
  output logic [7:0]              tbm_index,
  output logic [31:0]             tbm_address,
  input  logic                    tbm_free_ie,
  input  logic [3:0]              tbm_free_slot,
  output logic                    disp_valid,
  input  logic                    disp_ready,
  output logic [CDB_W-1:0]        disp_cdb,
  output logic                    err_oe,
  output logic [7:0]              err_tag,
  output logic                    fetch_timeout
);

  localparam int unsigned BEATS  = CDB_W / CMD_IO_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned GAP_W  = $clog2(BEAT_TIMEOUT + 1);
  localparam int unsigned SLOT_W = (TBM_SLOTS > 1) ? $clog2(TBM_SLOTS) : 1;

  fetch_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CDB_W-1:0]  cdb_q, cdb_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic              alloc_req;
  logic              alloc_gnt;
  logic [SLOT_W-1:0] alloc_slot;
  logic              all_busy;

  logic [7:0]  cdb_status;
  logic [7:0]  cdb_qidx;
  logic [7:0]  cdb_tag;
  logic [7:0]  cdb_op;
  logic [31:0] slot_addr;

  assign cdb_status = cdb_q[CDB_STATUS_LSB +: 8];
  assign cdb_qidx   = cdb_q[CDB_QIDX_LSB +: 8];
  assign cdb_tag    = cdb_q[CDB_TAG_LSB +: 8];
  assign cdb_op     = cdb_q[CDB_OP_LSB +: 8];
  // Natural 32-bit wrap gives the required truncation.
  assign slot_addr  = TBM_BASE + (32'(slot_q) * 32'(TBM_SLOT_BYTES));
  assign disp_cdb   = cdb_q;

  hv_tbm_alloc #(
    .SLOTS  (TBM_SLOTS),
    .SLOT_W (SLOT_W)
  ) u_alloc (
    .clk        (clk),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_slot (alloc_slot),
    .free_ie    (tbm_free_ie),
    .free_slot  (tbm_free_slot),
    .all_busy   (all_busy)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    cdb_d         = cdb_q;
    slot_d        = slot_q;
    cmd_request   = 1'b0;
    op_index      = 8'd0;
    cmd_op_status = 8'd0;
    tbm_ie        = 1'b0;
    tbm_index     = 8'd0;
    tbm_address   = 32'd0;
    disp_valid    = 1'b0;
    err_oe        = 1'b0;
    err_tag       = 8'd0;
    fetch_timeout = 1'b0;
    alloc_req     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cq_cout_ready) state_d = ST_REQ;
      end
      ST_REQ: begin
        cmd_request = 1'b1;
        beat_d      = '0;
        gap_d       = '0;
        state_d     = ST_CAP;
      end
      ST_CAP: begin
        // The gap counter only advances on empty cycles, so it measures
        // silence since the most recent beat (or since entering CAP).
        if (gap_q == GAP_W'(BEAT_TIMEOUT)) begin
          fetch_timeout = 1'b1;
          cdb_d         = '0;
          beat_d        = '0;
          gap_d         = '0;
          state_d       = ST_IDLE;
        end else if (cmd_oe) begin
          for (int b = 0; b < int'(BEATS); b++) begin
            if (beat_q == BEAT_W'(b)) cdb_d[b*CMD_IO_WIDTH +: CMD_IO_WIDTH] = cmd_out;
          end
          gap_d = '0;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = ST_DECODE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if ((cdb_status == CS_CKS_ERROR) || !op_supported(cdb_op)) begin
          err_oe  = 1'b1;
          err_tag = cdb_tag;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        alloc_req = 1'b1;
        if (alloc_gnt) begin
          slot_d  = alloc_slot;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        tbm_ie        = 1'b1;
        tbm_index     = cdb_qidx;
        op_index      = cdb_qidx;
        tbm_address   = slot_addr;
        cmd_op_status = (cdb_op == OP_WRITE) ? CS_H2M : CS_Q2S;
        cdb_d[CDB_TBM_LSB +: 32] = slot_addr;
        state_d       = ST_ISSUE;
      end
      ST_ISSUE: begin
        disp_valid = 1'b1;
        if (disp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      cdb_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      cdb_q   <= cdb_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: tb/tb_hv_cmd_fetch.sv
// Scoreboard bench for hv_cmd_fetch: the driver predicts responses from a slot
// list model into a queue, an independent monitor pops and compares them.
module tb_hv_cmd_fetch;

  localparam int K_UPD  = 0;
  localparam int K_ERR  = 1;
  localparam int K_TO   = 2;
  localparam int K_DISP = 3;

  typedef struct {
    int           kind;
    logic [7:0]   idx;
    logic [31:0]  addr;
    logic [7:0]   st;
    logic [7:0]   tag;
    logic [255:0] cdb;
    bit           chk_lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cq_cout_ready;
  logic         cmd_request;
  logic         cmd_oe;
  logic [63:0]  cmd_out;
  logic [7:0]   op_index;
  logic [7:0]   cmd_op_status;
  logic         tbm_ie;
  logic [7:0]   tbm_index;
  logic [31:0]  tbm_address;
  logic         tbm_free_ie;
  logic [3:0]   tbm_free_slot;
  logic         disp_valid;
  logic         disp_ready;
  logic [255:0] disp_cdb;
  logic         err_oe;
  logic [7:0]   err_tag;
  logic         fetch_timeout;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_beat_cyc = 0;
  int   stall_req = 0;
  bit   mon_en = 1'b0;
  bit   model_busy [16];

  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [255:0] prev_cdb = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hv_cmd_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .cq_cout_ready (cq_cout_ready),
    .cmd_request   (cmd_request),
    .cmd_oe        (cmd_oe),
    .cmd_out       (cmd_out),
    .op_index      (op_index),
    .cmd_op_status (cmd_op_status),
    .tbm_ie        (tbm_ie),
    .tbm_index     (tbm_index),
    .tbm_address   (tbm_address),
    .tbm_free_ie   (tbm_free_ie),
    .tbm_free_slot (tbm_free_slot),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_cdb      (disp_cdb),
    .err_oe        (err_oe),
    .err_tag       (err_tag),
    .fetch_timeout (fetch_timeout)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 16; i++) if (!model_busy[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (model_busy[i]) n++;
    return n;
  endfunction

  // Engine side: hold disp_ready low for stall_req cycles of each dispatch.
  initial begin
    int stall_cnt = 0;
    disp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (disp_valid) begin
        if (stall_cnt >= stall_req) disp_ready = 1'b1;
        else begin
          disp_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        disp_ready = 1'b0;
        stall_cnt  = 0;
      end
    end
  end

  // Monitor: every DUT output event must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else if (mon_en) begin
        if (tbm_ie) begin
          if (q.size() == 0 || q[0].kind != K_UPD) chk("unexpected_tbm_ie", {tbm_index, tbm_address}, 0);
          else begin
            e = q.pop_front();
            chk("tbm_index", tbm_index, e.idx);
            chk("op_index", op_index, e.idx);
            chk("tbm_address", tbm_address, e.addr);
            chk("cmd_op_status", cmd_op_status, e.st);
          end
        end else if (cmd_op_status != 8'd0 || op_index != 8'd0) begin
          chk("status_without_update", {op_index, cmd_op_status}, 0);
        end
        if (err_oe) begin
          if (q.size() == 0 || q[0].kind != K_ERR) chk("unexpected_err_oe", err_tag, 0);
          else begin
            e = q.pop_front();
            chk("err_tag", err_tag, e.tag);
            chk("err_no_update", {tbm_ie, cmd_op_status}, 0);
          end
        end
        if (fetch_timeout) begin
          if (q.size() == 0 || q[0].kind != K_TO) chk("unexpected_timeout", 1, 0);
          else begin
            e = q.pop_front();
            chk("timeout_cycle", cyc, last_beat_cyc + 16);
          end
        end
        if (disp_valid && !prev_valid) begin
          if (q.size() == 0 || q[0].kind != K_DISP) chk("unexpected_disp", disp_cdb, 0);
          else if (q[0].chk_lat) chk("disp_latency", cyc - last_beat_cyc, 3);
        end
        if (prev_valid && !prev_ready) begin
          chk("disp_valid_held", disp_valid, 1);
          chk("disp_cdb_stable", disp_cdb, prev_cdb);
        end
        if (disp_valid && cq_cout_ready) chk("no_req_in_issue", cmd_request, 0);
        if (disp_valid && disp_ready && q.size() > 0 && q[0].kind == K_DISP) begin
          e = q.pop_front();
          chk("disp_cdb", disp_cdb, e.cdb);
        end
        prev_valid = disp_valid;
        prev_ready = disp_ready;
        prev_cdb   = disp_cdb;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected responses come from the CDB fields and the slot list model.
  task automatic push_cmd(input logic [255:0] cdb, input bit chk_lat, input int force_slot);
    exp_t e;
    int   slot;
    logic [7:0] st = cdb[31:24];
    logic [7:0] op = cdb[7:0];
    e.kind = K_ERR; e.idx = 0; e.addr = 0; e.st = 0; e.tag = cdb[15:8]; e.cdb = 0; e.chk_lat = 0;
    if (st == 8'd1 || (op != 8'h01 && op != 8'h02)) begin
      q.push_back(e);
    end else begin
      slot = (force_slot >= 0) ? force_slot : lowest_free();
      model_busy[slot] = 1'b1;
      e.kind = K_UPD;
      e.idx  = cdb[23:16];
      e.addr = slot * 4096;
      e.st   = (op == 8'h01) ? 8'd4 : 8'd5;
      q.push_back(e);
      e.kind    = K_DISP;
      e.cdb     = cdb;
      e.cdb[191:160] = slot * 4096;
      e.chk_lat = chk_lat;
      q.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic [255:0] cdb, input int nbeats, input bit keep_ready);
    int k = 0;
    int gap;
    cq_cout_ready = 1'b1;
    cmd_oe  = 1'b1;  // stray beats outside capture must be ignored
    cmd_out = {$urandom(), $urandom()};
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_request && k < 20);
    chk("req_latency", k, 1);
    if (!cmd_request) return;
    if (!keep_ready) cq_cout_ready = 1'b0;
    @(negedge clk);
    for (int b = 0; b < nbeats; b++) begin
      gap = $urandom_range(0, 2);
      cmd_oe = 1'b0;
      repeat (gap) @(negedge clk);
      cmd_oe  = 1'b1;
      cmd_out = cdb[b*64 +: 64];
      @(negedge clk);
    end
    cmd_oe  = 1'b0;
    cmd_out = {$urandom(), $urandom()};
    last_beat_cyc = cyc;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || disp_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic free_slot(input int s);
    @(negedge clk);
    tbm_free_ie   = 1'b1;
    tbm_free_slot = s[3:0];
    @(negedge clk);
    tbm_free_ie = 1'b0;
    model_busy[s] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_request"}, cmd_request, 0);
    chk({tag, "_op_index"}, op_index, 0);
    chk({tag, "_cmd_op_status"}, cmd_op_status, 0);
    chk({tag, "_tbm"}, {tbm_ie, tbm_index, tbm_address}, 0);
    chk({tag, "_disp_valid"}, disp_valid, 0);
    chk({tag, "_disp_cdb"}, disp_cdb, 0);
    chk({tag, "_err"}, {err_oe, err_tag}, 0);
    chk({tag, "_fetch_timeout"}, fetch_timeout, 0);
  endtask

  function automatic logic [255:0] make_cdb(input logic [7:0] st, input logic [7:0] idx,
                                            input logic [7:0] tag, input logic [7:0] op);
    logic [255:0] c;
    for (int i = 0; i < 8; i++) c[i*32 +: 32] = $urandom();
    c[31:0] = {st, idx, tag, op};
    return c;
  endfunction

  task automatic run_cmd(input logic [255:0] cdb);
    push_cmd(cdb, 1'b1, -1);
    send_cmd(cdb, 4, 1'b0);
    drain();
  endtask

  initial begin
    logic [255:0] c;
    int r, s, n;
    reset = 1'b0; cq_cout_ready = 1'b0; cmd_oe = 1'b0; cmd_out = '0;
    tbm_free_ie = 1'b0; tbm_free_slot = '0;
    for (int i = 0; i < 16; i++) model_busy[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write then read, and a checksum error drop.
    run_cmd(make_cdb(8'd2, 8'd3, 8'h55, 8'h01));
    run_cmd(make_cdb(8'd2, 8'd4, 8'h21, 8'h02));
    run_cmd(make_cdb(8'd1, 8'd5, 8'hA7, 8'h01));
    run_cmd(make_cdb(8'd3, 8'd6, 8'h3C, 8'h07));

    // Randomized mix with frees, including frees of already-free slots.
    for (int t = 0; t < 24; t++) begin
      if (busy_count() >= 14 || $urandom_range(0, 9) < 3) begin
        do s = $urandom_range(0, 15); while (!model_busy[s] && busy_count() > 0);
        free_slot(s);
      end
      if ($urandom_range(0, 9) < 2 && lowest_free() >= 0) free_slot(lowest_free());
      r = $urandom_range(0, 9);
      c = make_cdb((r == 0) ? 8'd1 : 8'($urandom_range(2, 12)), 8'($urandom), 8'($urandom),
                   8'h01);
      r = $urandom_range(0, 5);
      c[7:0] = (r < 2) ? 8'h01 : (r < 4) ? 8'h02 : 8'($urandom_range(3, 255));
      stall_req = $urandom_range(0, 3);
      run_cmd(c);
    end
    stall_req = 0;

    // Fill every slot, then a command must park until slot 9 is released.
    while (lowest_free() >= 0) run_cmd(make_cdb(8'd2, 8'($urandom), 8'h11, 8'h01));
    c = make_cdb(8'd2, 8'h40, 8'h12, 8'h02);
    push_cmd(c, 1'b0, 9);
    send_cmd(c, 4, 1'b0);
    repeat (8) @(negedge clk);
    chk("parked_in_alloc", (q.size() > 0 && q[0].kind == K_UPD), 1);
    free_slot(9);
    model_busy[9] = 1'b1;
    drain();

    // Free and grant of the same slot in one cycle leaves it busy.
    free_slot(5);
    c = make_cdb(8'd2, 8'h41, 8'h13, 8'h01);
    push_cmd(c, 1'b1, -1);
    send_cmd(c, 4, 1'b0);
    @(negedge clk);
    tbm_free_ie = 1'b1;
    tbm_free_slot = 4'd5;
    @(negedge clk);
    tbm_free_ie = 1'b0;
    drain();
    c = make_cdb(8'd2, 8'h42, 8'h14, 8'h02);
    push_cmd(c, 1'b0, 12);
    send_cmd(c, 4, 1'b0);
    repeat (8) @(negedge clk);
    chk("parked_after_collision", (q.size() > 0 && q[0].kind == K_UPD), 1);
    free_slot(12);
    model_busy[12] = 1'b1;
    drain();

    // Two beats then silence.
    free_slot(3);
    begin
      exp_t e;
      e.kind = K_TO; e.idx = 0; e.addr = 0; e.st = 0; e.tag = 0; e.cdb = 0; e.chk_lat = 0;
      q.push_back(e);
    end
    send_cmd(make_cdb(8'd2, 8'h50, 8'h15, 8'h01), 2, 1'b0);
    drain();

    // Engine back-pressure for 10 cycles with the queue still offering work.
    stall_req = 10;
    c = make_cdb(8'd2, 8'h51, 8'h16, 8'h02);
    push_cmd(c, 1'b1, -1);
    send_cmd(c, 4, 1'b1);
    n = 0;
    r = 0;
    while (!(disp_valid && disp_ready) && r < 60) begin
      @(negedge clk);
      if (disp_valid && !disp_ready) n++;
      r++;
    end
    cq_cout_ready = 1'b0;
    chk("stall_cycles", n, 10);
    stall_req = 0;
    drain();

    // Reset in the middle of capture and in the middle of issue.
    send_cmd(make_cdb(8'd2, 8'h60, 8'h17, 8'h01), 2, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_cap");
    for (int i = 0; i < 16; i++) model_busy[i] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    stall_req = 100;
    c = make_cdb(8'd2, 8'h61, 8'h18, 8'h01);
    push_cmd(c, 1'b0, -1);
    send_cmd(c, 4, 1'b0);
    r = 0;
    while (!disp_valid && r < 20) begin
      @(negedge clk);
      r++;
    end
    chk("reached_issue", disp_valid, 1);
    reset = 1'b0;
    #1;
    q.delete();
    chk_reset_outputs("rst_issue");
    for (int i = 0; i < 16; i++) model_busy[i] = 1'b0;
    stall_req = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(make_cdb(8'd2, 8'h62, 8'h19, 8'h02));
    run_cmd(make_cdb(8'd2, 8'h63, 8'h1A, 8'h01));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
